// File: rtl/simon_input_capture.sv
// Simon answer capture: synchronises 16 pushbuttons, encodes presses and checks them against the
// expected sequence with a per-press timeout. Optional debounce is enabled by SIMON_DEBOUNCE_EN.
module simon_input_capture #(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 start_i,
  input  logic [3:0]           exp_len_i,
  input  logic [4*MAX_LEN-1:0] exp_seq_i,
  input  logic [15:0]          pb_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [3:0]           got_len_o,
  output logic [3:0]           last_code_o,
  output logic                 err_multi_o
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StHeld, StDone} state_e;

  state_e                      state_q;
  logic [15:0]                 pb_meta_q, pb_s_q;
  logic                        event_q, multi_q;
  logic [3:0]                  code_q;
  logic                        pb_idle;
  logic [3:0]                  code_c;
  logic                        multi_c;
  logic [MAX_LEN-1:0][3:0]     exp_q;
  logic [3:0]                  len_q, len_c, exp_sym;
  logic [3:0]                  got_len_q, last_code_q;
  logic [TmoW-1:0]             tmo_q;
  logic                        busy_q, done_q, pass_q, err_multi_q;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      pb_meta_q <= '0;
      pb_s_q    <= '0;
    end else begin
      pb_meta_q <= pb_i;
      pb_s_q    <= pb_meta_q;
    end
  end

  // Lowest set bit wins; a multi-press is flagged separately.
  always_comb begin
    code_c = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pb_s_q[i]) code_c = 4'(i);
    end
  end
  assign multi_c = |(pb_s_q & (pb_s_q - 16'd1));

`ifdef SIMON_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic [15:0]     db_last_q, db_q;
  logic [CntW-1:0] db_cnt_q, db_run;
  logic            db_stable;

  // db_run is the number of consecutive cycles pb_s has held its current value.
  always_comb begin
    if (pb_s_q != db_last_q)                    db_run = CntW'(1);
    else if (db_cnt_q == CntW'(DEBOUNCE_CYC))   db_run = db_cnt_q;
    else                                        db_run = db_cnt_q + CntW'(1);
  end
  assign db_stable = (db_run == CntW'(DEBOUNCE_CYC)) && (pb_s_q != db_q);
  assign pb_idle   = (db_q == '0);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      db_last_q <= '0;
      db_cnt_q  <= '0;
      db_q      <= '0;
      event_q   <= 1'b0;
      code_q    <= '0;
      multi_q   <= 1'b0;
    end else begin
      db_last_q <= pb_s_q;
      db_cnt_q  <= db_run;
      if (db_stable) db_q <= pb_s_q;
      event_q   <= db_stable && (db_q == '0) && (pb_s_q != '0);
      code_q    <= code_c;
      multi_q   <= multi_c;
    end
  end
`else
  logic pb_zero_q;

  assign pb_idle = (pb_s_q == '0);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      pb_zero_q <= 1'b1;
      event_q   <= 1'b0;
      code_q    <= '0;
      multi_q   <= 1'b0;
    end else begin
      pb_zero_q <= pb_idle;
      event_q   <= !pb_idle && pb_zero_q;
      code_q    <= code_c;
      multi_q   <= multi_c;
    end
  end
`endif

  assign len_c = ({28'd0, exp_len_i} > MAX_LEN) ? 4'(MAX_LEN) : exp_len_i;

  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (got_len_q == 4'(i)) exp_sym = exp_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= StIdle;
      exp_q       <= '0;
      len_q       <= '0;
      got_len_q   <= '0;
      last_code_q <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            exp_q       <= exp_seq_i;
            len_q       <= len_c;
            got_len_q   <= '0;
            pass_q      <= 1'b0;
            err_multi_q <= 1'b0;
            tmo_q       <= '0;
            if (len_c == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StWait;
              busy_q  <= 1'b1;
            end
          end
        end
        StWait: begin
          // A press in the same cycle as the timeout takes priority.
          if (event_q) begin
            last_code_q <= code_q;
            if (multi_q || (code_q != exp_sym)) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              err_multi_q <= multi_q;
            end else begin
              if (got_len_q != len_q) got_len_q <= got_len_q + 4'd1;
              state_q <= StHeld;
            end
          end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StHeld: begin
          if (pb_idle) begin
            if (got_len_q == len_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StWait;
              tmo_q   <= '0;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign got_len_o   = got_len_q;
  assign last_code_o = last_code_q;
  assign err_multi_o = err_multi_q;

endmodule

// File: tb/tb_simon_input_capture.sv
// Directed bench for simon_input_capture (default build, TIMEOUT_CYC = 20).
module tb_simon_input_capture;

  localparam int unsigned MaxLen = 8;

  logic                clk = 1'b0;
  logic                n_rst;
  logic                start;
  logic [3:0]          exp_len;
  logic [4*MaxLen-1:0] exp_seq;
  logic [15:0]         pb;
  logic                busy, done, pass, err_multi;
  logic [3:0]          got_len, last_code;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  simon_input_capture #(
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CYC (20),
    .DEBOUNCE_CYC(16)
  ) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .start_i    (start),
    .exp_len_i  (exp_len),
    .exp_seq_i  (exp_seq),
    .pb_i       (pb),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .got_len_o  (got_len),
    .last_code_o(last_code),
    .err_multi_o(err_multi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (n_rst && done) done_cnt++;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until done is seen (start is dropped after the first edge); -1 on expiry.
  task automatic wait_done(input int max, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (n < max) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) begin
        cyc = n;
        return;
      end
    end
  endtask

  task automatic press(input int idx);
    pb = 16'h1 << idx;
    step(5);
    pb = '0;
    step(4);
  endtask

  task automatic begin_round(input logic [3:0] len, input logic [31:0] seq);
    exp_len = len;
    exp_seq = seq;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
  endtask

  int cyc, cyc0, d0;
  int seq8[8] = '{0, 15, 1, 14, 7, 8, 3, 12};

  initial begin
    n_rst = 1'b0; start = 1'b0; exp_len = '0; exp_seq = '0; pb = '0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_got_len", got_len, 0);
    check_eq("rst_last_code", last_code, 0);
    check_eq("rst_err_multi", err_multi, 0);
    step(2);
    n_rst = 1'b1;
    step(2);

    // Correct sequence {5,2,9}
    d0 = done_cnt;
    begin_round(4'd3, 32'h0000_0925);
    check_eq("seq_busy", busy, 1);
    press(5);
    check_eq("seq_got1", got_len, 1);
    press(2);
    pb = 16'h1 << 9;
    step(5);
    pb = '0;
    wait_done(10, cyc);
    check_eq("seq_done_lat", cyc, 3);
    check_eq("seq_pass", pass, 1);
    check_eq("seq_got_len", got_len, 3);
    check_eq("seq_last_code", last_code, 9);
    check_eq("seq_busy_end", busy, 0);
    step(1);
    check_eq("seq_done_pulse", done, 0);
    step(3);
    check_eq("seq_done_count", done_cnt - d0, 1);

    // Wrong symbol: 5 then 7
    begin_round(4'd3, 32'h0000_0925);
    press(5);
    pb = 16'h1 << 7;
    wait_done(10, cyc);
    check_eq("wrong_lat", cyc, 4);
    check_eq("wrong_pass", pass, 0);
    check_eq("wrong_got_len", got_len, 1);
    check_eq("wrong_last_code", last_code, 7);
    check_eq("wrong_err_multi", err_multi, 0);
    pb = '0;
    step(4);

    // Multi-press 3+4
    begin_round(4'd2, 32'h0000_0043);
    pb = 16'h0018;
    wait_done(10, cyc);
    check_eq("multi_lat", cyc, 4);
    check_eq("multi_pass", pass, 0);
    check_eq("multi_err", err_multi, 1);
    check_eq("multi_got_len", got_len, 0);
    pb = '0;
    step(4);

    // Timeout, with a start issued mid-round that must be ignored
    exp_len = 4'd1; exp_seq = 32'h0000_0006; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check_eq("tmo_pass_cleared", pass, 0);
    check_eq("tmo_err_cleared", err_multi, 0);
    exp_len = 4'd0; start = 1'b1;
    wait_done(40, cyc0);
    cyc = (cyc0 < 0) ? -1 : cyc0 + 5;
    check_eq("tmo_lat_in_range", (cyc >= 21 && cyc <= 22) ? 1 : 0, 1);
    check_eq("tmo_pass", pass, 0);
    check_eq("tmo_got_len", got_len, 0);
    step(3);

    // Zero length
    exp_len = 4'd0; start = 1'b1;
    wait_done(5, cyc);
    check_eq("zero_lat", cyc, 1);
    check_eq("zero_pass", pass, 1);
    step(2);

    // Button held through start gives no event until re-pressed
    pb = 16'h1 << 5;
    step(4);
    begin_round(4'd1, 32'h0000_0005);
    step(5);
    check_eq("held_no_event", got_len, 0);
    check_eq("held_busy", busy, 1);
    pb = '0;
    step(4);
    pb = 16'h1 << 5;
    step(5);
    pb = '0;
    wait_done(10, cyc);
    check_eq("held_repress_lat", cyc, 3);
    check_eq("held_repress_pass", pass, 1);
    step(2);

    // Length clamp: 15 -> 8
    begin_round(4'd15, 32'hC387_E1F0);
    for (int i = 0; i < 7; i++) press(seq8[i]);
    check_eq("clamp_got7", got_len, 7);
    pb = 16'h1 << seq8[7];
    step(5);
    pb = '0;
    wait_done(10, cyc);
    check_eq("clamp_lat", cyc, 3);
    check_eq("clamp_pass", pass, 1);
    check_eq("clamp_got_len", got_len, 8);
    check_eq("clamp_last_code", last_code, 12);
    step(2);

    // Reset mid-round
    begin_round(4'd3, 32'h0000_0925);
    press(5);
    check_eq("rstmid_got1", got_len, 1);
    d0 = done_cnt;
    n_rst = 1'b0;
    #1;
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_got_len", got_len, 0);
    check_eq("rstmid_last_code", last_code, 0);
    check_eq("rstmid_pass", pass, 0);
    step(2);
    n_rst = 1'b1;
    step(25);
    check_eq("rstmid_no_done", done_cnt - d0, 0);
    check_eq("rstmid_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_input_capture.md
Name: simon_input_capture

Overview:
- Receive side of the Simon sequence exchange: the LED shifter plays the sequence to the player, and this block collects the player's pushbutton answer.
- Synchronises and edge-detects the 16 pushbuttons, encodes each press to a 4-bit symbol, and compares it on the fly against the expected sequence.
- Reports pass/fail to the game FSM with a start/done handshake, and enforces a per-press timeout.

Parameters:
- MAX_LEN, 8, maximum sequence length in symbols.
- TIMEOUT_CYC, 1000, clk cycles allowed between presses before fail.
- DEBOUNCE_CYC, 16, stable cycles required before a press is accepted (used only with SIMON_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  1-cycle pulse; begins a capture round.
- exp_len  in  4  expected number of symbols; sampled on start.
- exp_seq  in  4*MAX_LEN  expected symbols; symbol k is exp_seq[4k+3:4k]; sampled on start.
- pb  in  16  raw pushbuttons, asynchronous, active-high.
- busy  out  1  high while a round is in progress.
- done  out  1  1-cycle pulse at the end of a round.
- pass  out  1  result of the last round; valid from done until the next start.
- got_len  out  4  symbols accepted in the current or last round.
- last_code  out  4  most recent encoded press.
- err_multi  out  1  last round failed because several buttons were pressed together.

Behaviour:
- Reset: state IDLE; busy, done, pass, err_multi = 0; got_len, last_code = 0; synchroniser and timeout counter cleared.
- Reset asserted mid-round aborts the round immediately; no done pulse is produced.
- pb passes through a 2-flop synchroniser (pb_s).
- A press event is pb_s going from all-zero to nonzero.
  - Event appears 3 cycles after the raw pb edge: 2 sync stages + 1 edge register.
- Encoding: code = index of the set bit in pb_s.
  - If popcount(pb_s) > 1 at the event, the press is a multi-press.
- Load on start (IDLE only): exp_seq is latched; len_q = min(exp_len, MAX_LEN); got_len is cleared; pass and err_multi are cleared.
- States and transitions:
  - IDLE:
    - start with len_q = 0 -> DONE, pass = 1.
    - start otherwise -> WAIT.
    - start while not in IDLE is ignored.
  - WAIT (busy = 1):
    - Timeout counter increments each cycle.
    - Counter reaching TIMEOUT_CYC-1 with no event -> DONE, pass = 0.
    - On a press event: last_code <= code.
      - Multi-press -> DONE, pass = 0, err_multi = 1.
      - code != exp symbol[got_len] -> DONE, pass = 0.
      - Otherwise got_len increments and state -> HELD.
  - HELD (busy = 1):
    - Waits for pb_s all-zero; the timeout counter does not run here.
    - On release: if got_len == len_q -> DONE, pass = 1; else -> WAIT with the counter cleared.
  - DONE: done = 1 for exactly one cycle, busy = 0, then -> IDLE.
- Simultaneous events:
  - Timeout and a press in the same cycle: the press wins.
  - A button already held when start arrives gives no event until it is released and pressed again.
- got_len saturates at len_q and never wraps.
- The timeout counter is $clog2(TIMEOUT_CYC) bits and is cleared on entry to WAIT.

Optional Feature:
- Macro: SIMON_DEBOUNCE_EN.
- Defined:
  - A press event requires pb_s nonzero and unchanged for DEBOUNCE_CYC consecutive cycles.
  - The event fires on the cycle the stability count completes, adding DEBOUNCE_CYC cycles of latency.
  - Release requires pb_s all-zero for DEBOUNCE_CYC cycles before leaving HELD.
  - Any change in pb_s restarts the stability count.
- Undefined: no debounce logic; behaviour is exactly as above.

Test Plan:
- Correct sequence: reset, start with exp_len=3, exp_seq symbols {5,2,9}; press pb[5], pb[2], pb[9], releasing between each -> single done pulse after the last release, pass=1, got_len=3, last_code=9.
- Wrong symbol: same setup; press pb[5] then pb[7] -> done 4 cycles after the raw pb[7] edge (3-cycle event latency + DONE), pass=0, got_len=1, last_code=7.
- Multi-press: start with exp_len=2; press pb[3] and pb[4] together -> done, pass=0, err_multi=1, got_len=0.
- Timeout: TIMEOUT_CYC=20; start with exp_len=1 and no press -> done 21–22 cycles after start, pass=0; start issued while busy is ignored.
- Zero length and clamp: start with exp_len=0 -> done the next cycle, pass=1. Start with exp_len=15 and MAX_LEN=8 -> a round of 8 correct presses passes with got_len=8.
- Reset mid-round: assert n_rst after the 1st correct press -> all outputs return to reset values and no done pulse appears. With SIMON_DEBOUNCE_EN, a 5-cycle pb glitch (DEBOUNCE_CYC=16) -> no event.
